// File: rtl/joy_sega6_reader.sv
`default_nettype none
// ============================================================================
// Module  : joy_sega6_reader
// Brief   : Dual DB9 pad scanner (SMS / MD 3-button / MD 6-button) driven by
//           hsync ticks; publishes active-high MXYZ SACB RLDU words per port.
// Revision: 1.0
// ============================================================================
module joy_sega6_reader #(
    parameter int CYCLE_LEN   = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        hs_i,
    input  logic [5:0]  joy1_pins_i,
    input  logic [5:0]  joy2_pins_i,
    output logic        joyX_p7_o,
    output logic [11:0] joy1_o,
    output logic [11:0] joy2_o,
    output logic        six1_o,
    output logic        six2_o,
    output logic        scan_done_o
);

    localparam int                c_PH_W = $clog2(CYCLE_LEN);
    localparam logic [c_PH_W-1:0] c_LAST = c_PH_W'(CYCLE_LEN - 1);
    localparam logic [c_PH_W-1:0] c_PH2  = c_PH_W'(2);
    localparam logic [c_PH_W-1:0] c_PH3  = c_PH_W'(3);
    localparam logic [c_PH_W-1:0] c_PH5  = c_PH_W'(5);
    localparam logic [c_PH_W-1:0] c_PH6  = c_PH_W'(6);
    localparam logic [c_PH_W-1:0] c_PH7  = c_PH_W'(7);

    logic [SYNC_STAGES-1:0][11:0] r_pad_sync;
    logic [SYNC_STAGES-1:0]       r_hs_sync;
    logic                         r_hs_prev;
    logic                         r_tick;
    logic                         w_hs_s;
    logic [11:0]                  w_pads;

    assign w_hs_s = r_hs_sync[SYNC_STAGES-1];
    assign w_pads = r_pad_sync[SYNC_STAGES-1];

    // hs chain resets low so a high hs_i after reset is a rise, never a false tick
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_pad_sync <= '1;
            r_hs_sync  <= '0;
            r_hs_prev  <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_pad_sync <= {r_pad_sync[SYNC_STAGES-2:0], joy2_pins_i, joy1_pins_i};
            r_hs_sync  <= {r_hs_sync[SYNC_STAGES-2:0], hs_i};
            r_hs_prev  <= w_hs_s;
            r_tick     <= r_hs_prev & ~w_hs_s;
        end
    end

    logic [c_PH_W-1:0] r_phase;
    logic              r_p7;
    logic              r_done;
    logic              w_in_seq;

    assign w_in_seq = (r_phase <= c_PH7);

    // Phases 0..7 toggle P7 starting low; everything afterwards parks it high
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_phase <= '0;
            r_p7    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_tick) begin
                r_phase <= (r_phase == c_LAST) ? '0 : r_phase + c_PH_W'(1);
                r_p7    <= w_in_seq ? r_phase[0] : 1'b1;
                r_done  <= (r_phase == c_PH7);
            end
        end
    end

    logic [1:0][11:0] w_joy;
    logic [1:0]       w_six;

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic [5:0]  w_pins;
        logic [11:0] r_scratch;
        logic        r_six;
        logic [11:0] r_joy;
        logic        r_six_out;

        assign w_pins = w_pads[p*6 +: 6];

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                r_scratch <= 12'hFFF;
                r_six     <= 1'b0;
                r_joy     <= '0;
                r_six_out <= 1'b0;
            end else if (r_tick) begin
                case (r_phase)
                    c_PH2: begin
                        r_scratch[5:0]  <= w_pins;
                        r_scratch[11:6] <= 6'h3F;
                        r_six           <= 1'b0;
                    end
                    // Right+Left both low while P7 is low only happens on a Mega Drive pad
                    c_PH3: begin
                        if (w_pins[3:2] == 2'b00)
                            r_scratch[7:6] <= w_pins[5:4];
                        else
                            r_scratch[7:4] <= {2'b11, w_pins[5:4]};
                    end
                    c_PH5: begin
                        if (w_pins[3:0] == 4'b0000)
                            r_six <= 1'b1;
                    end
                    c_PH6: begin
                        if (r_six)
                            r_scratch[11:8] <= w_pins[3:0];
                    end
                    c_PH7: begin
                        r_joy     <= ~r_scratch;
                        r_six_out <= r_six;
                    end
                    default: ;
                endcase
            end
        end

        assign w_joy[p] = r_joy;
        assign w_six[p] = r_six_out;
    end

    assign joyX_p7_o   = r_p7;
    assign joy1_o      = w_joy[0];
    assign joy2_o      = w_joy[1];
    assign six1_o      = w_six[0];
    assign six2_o      = w_six[1];
    assign scan_done_o = r_done;

endmodule
`default_nettype wire
